ex_stage_pipe: RTL and testbench
================================

# ex_stage_pipe

Parametrised execute stage for the in-order pipeline: forwarding-operand muxes, ALU, optional iterative multiplier, and the EX/MEM pipeline latch in one block. It sits between the ID/EX latch and the memory stage. It requests a pipeline stall (`busy`) while a multi-cycle multiply is in progress. It adds configurable datapath width and forwarding-source count, which the previous execute interface lacked.

## Interface
Parameters:
- `WIDTH`, 32, datapath width.
- `SHAM_W`, 5, shift-amount width; 2**SHAM_W must equal WIDTH.
- `REGSEL_W`, 5, destination register index width.
- `N_FWD`, 2, forwarding sources (1..3).

Ports (clock and reset as decided: one clock `CLK`; reset `RST` is asynchronous and active-high):
- `CLK` in 1: clock.
- `RST` in 1: async active-high reset.
- `ihit` in 1: pipeline advance enable.
- `flush` in 1: squash EX/MEM latch contents.
- `in_valid` in 1: ID/EX holds a real instruction.
- `nPC` in WIDTH: pass-through.
- `dREN`, `dWEN`, `regWr` in 1 each: pass-through controls.
- `regDst` in REGSEL_W: pass-through.
- `rdat1`, `rdat2`, `imm` in WIDTH: operands.
- `shamt` in SHAM_W: shift amount.
- `ALUOp` in 4: 0 SLL, 1 SRL, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 SLT, 9 SLTU, 10 MUL, 11–15 result 0.
- `ALUSrc` in 2: opB select; 0 fwd B, 1 `imm`, 2 zero-extended `shamt`, 3 treated as 0.
- `fwdSelA`, `fwdSelB` in 2: 0 register, k = `fwdData` slot k-1; k>N_FWD selects register.
- `fwdData` in N_FWD*WIDTH: slot i at bits [i*WIDTH +: WIDTH].
- `busy` out 1: combinational stall request.
- `equal` out 1: combinational, forwarded A == forwarded B.
- `valid_next`, `dREN_next`, `dWEN_next`, `regWr_next` out 1: latched.
- `nPC_next`, `ALUOut_next`, `stData_next` out WIDTH: latched; `stData_next` is forwarded B before ALUSrc.
- `regDst_next` out REGSEL_W: latched.

## Operation
- opA = forwarded rdat1. fB = forwarded rdat2. opB = ALUSrc mux of fB.
- SLL/SRL: opA shifted by opB[SHAM_W-1:0], logical. ADD/SUB wrap modulo 2**WIDTH, no overflow flag. SLT signed, SLTU unsigned; result is 1 or 0, zero-extended.
- MUL: low WIDTH bits of opA*opB, computed by a radix-2 shift-add engine.
- Multiplier FSM states:
  - IDLE → MUL when in_valid && ALUOp==MUL && !flush. Loads operands; counter=0.
  - MUL: one bit per cycle. After WIDTH iterations (counter==WIDTH-1) → DONE.
  - DONE: product held. → IDLE on the latch capture.
- `busy` = 1 in IDLE while a MUL request is present, and in every MUL cycle. `busy` = 0 in DONE.
- EX/MEM latch priority per cycle:
  - flush: all latched outputs 0, FSM → IDLE.
  - else ihit && !busy: capture. `valid_next`=in_valid; controls are ANDed with in_valid.
  - else hold.
- Reset: every latched output 0, FSM IDLE, counter 0.

## Timing
- Non-MUL ops: 1-cycle latency; captured at the first edge with ihit && !busy.
- MUL: busy for WIDTH+1 cycles (request cycle plus WIDTH MUL cycles). Earliest capture is the DONE-cycle edge; total WIDTH+2 cycles from presentation.
- Upstream must hold ID/EX inputs stable while busy=1. Operand changes during MUL are ignored.
- If ihit=0 in DONE, stay in DONE holding the product until ihit.
- Flush during MUL/DONE aborts the multiply: FSM IDLE next cycle, latch cleared.
- Flush and capture in the same cycle: flush wins.
- Reset mid-multiply: FSM IDLE immediately (async), busy drops in the same cycle.

## Configuration
- `EX_MUL_EN` defined: multiplier FSM and MUL op built as above.
- `EX_MUL_EN` undefined: no FSM. ALUOp 10 gives result 0, `busy` is tied 0, and all ops are single-cycle.

## Test plan
- Reset: RST=1 mid-run → all `*_next` outputs 0, busy=0. After release, ADD 5+7 with ihit=1 → ALUOut_next=12, valid_next=1 after one edge.
- Forwarding: rdat1=1, fwdData slot1=0x100, fwdSelA=2, SUB opB=imm 0x1 → ALUOut_next=0xFF. fwdSelA=3 with N_FWD=2 → register value used.
- Compare: SLT 0xFFFFFFFF vs 1 → 1. SLTU with the same operands → 0. rdat1=rdat2=0x55 → equal=1.
- MUL 0xFFFF×0x10001 (WIDTH=32) → busy high exactly 33 cycles. ALUOut_next=0xFFFFFFFF captured on the 34th edge. With ihit=0 in DONE, output holds until ihit.
- Flush at MUL cycle 10 → busy=0 next cycle, latch all 0. A following ADD completes in 1 cycle.
- Without `EX_MUL_EN`: MUL 3×4 → ALUOut_next=0, busy never asserts.

Source files
------------

// File: rtl/ex_stage_pipe_if.sv
// ex_stage_pipe_if: ID/EX operand and control bundle into the execute stage,
// plus the EX/MEM latch outputs and stall/compare results coming back.
interface ex_stage_pipe_if #(
  parameter int WIDTH    = 32,
  parameter int SHAM_W   = 5,
  parameter int REGSEL_W = 5,
  parameter int N_FWD    = 2
);
  logic                   ihit;
  logic                   flush;
  logic                   in_valid;
  logic [WIDTH-1:0]       nPC;
  logic                   dREN;
  logic                   dWEN;
  logic                   regWr;
  logic [REGSEL_W-1:0]    regDst;
  logic [WIDTH-1:0]       rdat1;
  logic [WIDTH-1:0]       rdat2;
  logic [WIDTH-1:0]       imm;
  logic [SHAM_W-1:0]      shamt;
  logic [3:0]             ALUOp;
  logic [1:0]             ALUSrc;
  logic [1:0]             fwdSelA;
  logic [1:0]             fwdSelB;
  logic [N_FWD*WIDTH-1:0] fwdData;

  logic                   busy;
  logic                   equal;
  logic                   valid_next;
  logic                   dREN_next;
  logic                   dWEN_next;
  logic                   regWr_next;
  logic [WIDTH-1:0]       nPC_next;
  logic [WIDTH-1:0]       ALUOut_next;
  logic [WIDTH-1:0]       stData_next;
  logic [REGSEL_W-1:0]    regDst_next;

  modport master (
    output ihit, flush, in_valid, nPC, dREN, dWEN, regWr, regDst,
           rdat1, rdat2, imm, shamt, ALUOp, ALUSrc, fwdSelA, fwdSelB, fwdData,
    input  busy, equal, valid_next, dREN_next, dWEN_next, regWr_next,
           nPC_next, ALUOut_next, stData_next, regDst_next
  );

  modport slave (
    input  ihit, flush, in_valid, nPC, dREN, dWEN, regWr, regDst,
           rdat1, rdat2, imm, shamt, ALUOp, ALUSrc, fwdSelA, fwdSelB, fwdData,
    output busy, equal, valid_next, dREN_next, dWEN_next, regWr_next,
           nPC_next, ALUOut_next, stData_next, regDst_next
  );
endinterface

// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: operand forwarding, ALU, EX/MEM latch and, when EX_MUL_EN is
// defined, a radix-2 shift-add multiplier that stalls the pipe via busy.
module ex_stage_pipe #(
  parameter int WIDTH    = 32,
  parameter int SHAM_W   = 5,
  parameter int REGSEL_W = 5,
  parameter int N_FWD    = 2
) (
  input logic            CLK,
  input logic            RST,
  ex_stage_pipe_if.slave bus
);
  localparam logic [3:0] OP_SLL  = 4'd0;
  localparam logic [3:0] OP_SRL  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOR  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  logic [WIDTH-1:0]    op_a_s;
  logic [WIDTH-1:0]    fwd_b_s;
  logic [WIDTH-1:0]    op_b_s;
  logic [WIDTH-1:0]    alu_s;
  logic [WIDTH-1:0]    mul_res_s;
  logic                busy_s;
  logic                capture_s;

  logic                valid_r;
  logic                dren_r;
  logic                dwen_r;
  logic                regwr_r;
  logic [WIDTH-1:0]    npc_r;
  logic [WIDTH-1:0]    aluout_r;
  logic [WIDTH-1:0]    stdata_r;
  logic [REGSEL_W-1:0] regdst_r;

  // Selector 0 or any selector beyond the populated slots keeps the register value.
  function automatic logic [WIDTH-1:0] fwd_pick(
    input logic [1:0]             sel,
    input logic [WIDTH-1:0]       reg_val,
    input logic [N_FWD*WIDTH-1:0] data
  );
    logic [WIDTH-1:0] r;
    r = reg_val;
    for (int k = 1; k <= N_FWD; k++) begin
      r = (sel == 2'(k)) ? data[(k-1)*WIDTH +: WIDTH] : r;
    end
    return r;
  endfunction

  assign op_a_s    = fwd_pick(bus.fwdSelA, bus.rdat1, bus.fwdData);
  assign fwd_b_s   = fwd_pick(bus.fwdSelB, bus.rdat2, bus.fwdData);
  assign bus.equal = (op_a_s == fwd_b_s);

  // Operand B source select
  always_comb begin
    op_b_s = {WIDTH{1'b0}};
    case (bus.ALUSrc)
      2'd0:    op_b_s = fwd_b_s;
      2'd1:    op_b_s = bus.imm;
      2'd2:    op_b_s = {{(WIDTH-SHAM_W){1'b0}}, bus.shamt};
      default: op_b_s = {WIDTH{1'b0}};
    endcase
  end

  // ALU result
  always_comb begin
    alu_s = {WIDTH{1'b0}};
    case (bus.ALUOp)
      OP_SLL:  alu_s = op_a_s << op_b_s[SHAM_W-1:0];
      OP_SRL:  alu_s = op_a_s >> op_b_s[SHAM_W-1:0];
      OP_ADD:  alu_s = op_a_s + op_b_s;
      OP_SUB:  alu_s = op_a_s - op_b_s;
      OP_AND:  alu_s = op_a_s & op_b_s;
      OP_OR:   alu_s = op_a_s | op_b_s;
      OP_XOR:  alu_s = op_a_s ^ op_b_s;
      OP_NOR:  alu_s = ~(op_a_s | op_b_s);
      OP_SLT:  alu_s = {{(WIDTH-1){1'b0}}, ($signed(op_a_s) < $signed(op_b_s))};
      OP_SLTU: alu_s = {{(WIDTH-1){1'b0}}, (op_a_s < op_b_s)};
      OP_MUL:  alu_s = mul_res_s;
      default: alu_s = {WIDTH{1'b0}};
    endcase
  end

`ifdef EX_MUL_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } mul_state_t;

  mul_state_t       state_r;
  mul_state_t       state_s;
  logic [SHAM_W-1:0] cnt_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] prod_r;
  logic             mul_req_s;
  logic             fsm_busy_s;

  assign mul_req_s = bus.in_valid && (bus.ALUOp == OP_MUL);
  assign mul_res_s = prod_r;
  // Reset forces IDLE asynchronously, so the stall must drop with it.
  assign busy_s    = fsm_busy_s && !RST;

  // Multiplier state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Multiplier next state and stall request
  always_comb begin
    state_s    = state_r;
    fsm_busy_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        fsm_busy_s = mul_req_s;
        if (bus.flush)      state_s = S_IDLE;
        else if (mul_req_s) state_s = S_MUL;
        else                state_s = S_IDLE;
      end
      S_MUL: begin
        fsm_busy_s = 1'b1;
        if (bus.flush)                          state_s = S_IDLE;
        else if (cnt_r == SHAM_W'(WIDTH - 1))   state_s = S_DONE;
        else                                    state_s = S_MUL;
      end
      S_DONE: begin
        if (bus.flush || bus.ihit) state_s = S_IDLE;
        else                       state_s = S_DONE;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Shift-add datapath: one multiplier bit per MUL cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_r    <= {SHAM_W{1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      prod_r   <= {WIDTH{1'b0}};
    end else if (state_r == S_IDLE && state_s == S_MUL) begin
      cnt_r    <= {SHAM_W{1'b0}};
      mcand_r  <= op_a_s;
      mplier_r <= op_b_s;
      prod_r   <= {WIDTH{1'b0}};
    end else if (state_r == S_MUL) begin
      cnt_r    <= cnt_r + 1'b1;
      mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
      prod_r   <= mplier_r[0] ? (prod_r + mcand_r) : prod_r;
    end
  end
`else
  assign mul_res_s = {WIDTH{1'b0}};
  assign busy_s    = 1'b0;
`endif

  assign bus.busy = busy_s;
  assign capture_s = bus.ihit && !busy_s;

  // EX/MEM latch: flush beats capture, otherwise hold
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_r  <= 1'b0;
      dren_r   <= 1'b0;
      dwen_r   <= 1'b0;
      regwr_r  <= 1'b0;
      npc_r    <= {WIDTH{1'b0}};
      aluout_r <= {WIDTH{1'b0}};
      stdata_r <= {WIDTH{1'b0}};
      regdst_r <= {REGSEL_W{1'b0}};
    end else if (bus.flush) begin
      valid_r  <= 1'b0;
      dren_r   <= 1'b0;
      dwen_r   <= 1'b0;
      regwr_r  <= 1'b0;
      npc_r    <= {WIDTH{1'b0}};
      aluout_r <= {WIDTH{1'b0}};
      stdata_r <= {WIDTH{1'b0}};
      regdst_r <= {REGSEL_W{1'b0}};
    end else if (capture_s) begin
      valid_r  <= bus.in_valid;
      dren_r   <= bus.dREN && bus.in_valid;
      dwen_r   <= bus.dWEN && bus.in_valid;
      regwr_r  <= bus.regWr && bus.in_valid;
      npc_r    <= bus.nPC;
      aluout_r <= alu_s;
      stdata_r <= fwd_b_s;
      regdst_r <= bus.regDst;
    end
  end

  assign bus.valid_next  = valid_r;
  assign bus.dREN_next   = dren_r;
  assign bus.dWEN_next   = dwen_r;
  assign bus.regWr_next  = regwr_r;
  assign bus.nPC_next    = npc_r;
  assign bus.ALUOut_next = aluout_r;
  assign bus.stData_next = stdata_r;
  assign bus.regDst_next = regdst_r;
endmodule

// File: tb/tb_ex_stage_pipe.sv
// tb_ex_stage_pipe: directed vectors for ex_stage_pipe with a cycle-level
// reference model; expectations follow EX_MUL_EN when it is defined.
module tb_ex_stage_pipe;
  localparam int W  = 32;
  localparam int SH = 5;
  localparam int RW = 5;
  localparam int NF = 2;
`ifdef EX_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  ex_stage_pipe_if #(.WIDTH(W), .SHAM_W(SH), .REGSEL_W(RW), .N_FWD(NF)) bus ();

  ex_stage_pipe #(.WIDTH(W), .SHAM_W(SH), .REGSEL_W(RW), .N_FWD(NF)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: expected latch contents and cycles into a multiply
  logic          m_valid, m_dren, m_dwen, m_regwr;
  logic [W-1:0]  m_npc, m_alu, m_st;
  logic [RW-1:0] m_regdst;
  int            m_cnt;

  function automatic logic [W-1:0] m_fwd(input logic [1:0] sel, input logic [W-1:0] r);
    if (sel == 2'd0 || int'(sel) > NF) return r;
    return bus.fwdData[(int'(sel) - 1) * W +: W];
  endfunction

  function automatic logic [W-1:0] m_opb();
    case (bus.ALUSrc)
      2'd0:    return m_fwd(bus.fwdSelB, bus.rdat2);
      2'd1:    return bus.imm;
      2'd2:    return W'(bus.shamt);
      default: return '0;
    endcase
  endfunction

  function automatic logic [W-1:0] m_result();
    logic [W-1:0] a, b;
    a = m_fwd(bus.fwdSelA, bus.rdat1);
    b = m_opb();
    case (bus.ALUOp)
      4'd0:    return a << (b % W);
      4'd1:    return a >> (b % W);
      4'd2:    return a + b;
      4'd3:    return a - b;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return a ^ b;
      4'd7:    return ~(a | b);
      4'd8:    return ($signed(a) < $signed(b)) ? 1 : 0;
      4'd9:    return (a < b) ? 1 : 0;
      4'd10:   return MUL_EN ? W'(a * b) : '0;
      default: return '0;
    endcase
  endfunction

  function automatic logic m_busy();
    if (!MUL_EN || rst) return 1'b0;
    if (m_cnt == 0) return bus.in_valid && bus.ALUOp == 4'd10;
    return m_cnt <= W;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst || bus.flush) begin
      m_valid <= 1'b0; m_dren <= 1'b0; m_dwen <= 1'b0; m_regwr <= 1'b0;
      m_npc <= '0; m_alu <= '0; m_st <= '0; m_regdst <= '0; m_cnt <= 0;
    end else if (bus.ihit && !m_busy()) begin
      m_valid  <= bus.in_valid;
      m_dren   <= bus.dREN && bus.in_valid;
      m_dwen   <= bus.dWEN && bus.in_valid;
      m_regwr  <= bus.regWr && bus.in_valid;
      m_npc    <= bus.nPC;
      m_alu    <= m_result();
      m_st     <= m_fwd(bus.fwdSelB, bus.rdat2);
      m_regdst <= bus.regDst;
      m_cnt    <= 0;
    end else if (MUL_EN && (m_cnt != 0 || (bus.in_valid && bus.ALUOp == 4'd10)) && m_cnt <= W) begin
      m_cnt <= m_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    check("cmp_valid",  64'(bus.valid_next),  64'(m_valid));
    check("cmp_dren",   64'(bus.dREN_next),   64'(m_dren));
    check("cmp_dwen",   64'(bus.dWEN_next),   64'(m_dwen));
    check("cmp_regwr",  64'(bus.regWr_next),  64'(m_regwr));
    check("cmp_npc",    64'(bus.nPC_next),    64'(m_npc));
    check("cmp_aluout", 64'(bus.ALUOut_next), 64'(m_alu));
    check("cmp_stdata", 64'(bus.stData_next), 64'(m_st));
    check("cmp_regdst", 64'(bus.regDst_next), 64'(m_regdst));
    check("cmp_busy",   64'(bus.busy),        64'(m_busy()));
    check("cmp_equal",  64'(bus.equal),
          64'(m_fwd(bus.fwdSelA, bus.rdat1) == m_fwd(bus.fwdSelB, bus.rdat2)));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] src, input logic [W-1:0] immv);
    bus.in_valid = 1'b1; bus.ALUOp = op; bus.rdat1 = a; bus.rdat2 = b;
    bus.ALUSrc = src; bus.imm = immv; bus.fwdSelA = 2'd0; bus.fwdSelB = 2'd0;
    bus.shamt = '0; bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.regWr = 1'b1;
    bus.regDst = 5'd1; bus.nPC = 32'h0000_0100; bus.flush = 1'b0; bus.ihit = 1'b1;
  endtask

  int busy_cnt;

  initial begin
    bus.fwdData = '0;
    instr(4'd2, 32'd0, 32'd0, 2'd0, 32'd0);
    bus.in_valid = 1'b0;
    step(); step();
    check("reset_valid", 64'(bus.valid_next), 64'd0);
    check("reset_busy",  64'(bus.busy), 64'd0);
    rst = 1'b0;

    instr(4'd2, 32'd5, 32'd7, 2'd0, 32'd0);
    bus.regDst = 5'd3; bus.nPC = 32'h40;
    step();
    check("add_5_7",    64'(bus.ALUOut_next), 64'd12);
    check("add_valid",  64'(bus.valid_next), 64'd1);
    check("add_regdst", 64'(bus.regDst_next), 64'd3);
    check("add_npc",    64'(bus.nPC_next), 64'h40);

    instr(4'd3, 32'd1, 32'd0, 2'd1, 32'd1);
    bus.fwdData = {32'h0000_0100, 32'h0000_0020};
    bus.fwdSelA = 2'd2;
    step();
    check("fwd_slot1_sub", 64'(bus.ALUOut_next), 64'hFF);
    bus.fwdSelA = 2'd3;
    step();
    check("fwd_sel3_reg", 64'(bus.ALUOut_next), 64'd0);
    instr(4'd2, 32'd1, 32'd9, 2'd0, 32'd0);
    bus.fwdSelB = 2'd1;
    step();
    check("fwd_b_add",   64'(bus.ALUOut_next), 64'h21);
    check("fwd_b_store", 64'(bus.stData_next), 64'h20);

    instr(4'd8, 32'hFFFF_FFFF, 32'd1, 2'd0, 32'd0);
    step();
    check("slt_neg", 64'(bus.ALUOut_next), 64'd1);
    bus.ALUOp = 4'd9;
    step();
    check("sltu_big", 64'(bus.ALUOut_next), 64'd0);

    instr(4'd2, 32'h55, 32'h55, 2'd0, 32'd0);
    #1 check("equal_55", 64'(bus.equal), 64'd1);
    bus.rdat2 = 32'h54;
    #1 check("equal_ne", 64'(bus.equal), 64'd0);

    instr(4'd0, 32'd1, 32'd0, 2'd2, 32'd0);
    bus.shamt = 5'd4;
    step();
    check("sll_shamt", 64'(bus.ALUOut_next), 64'h10);
    instr(4'd1, 32'h8000_0000, 32'd0, 2'd1, 32'd31);
    step();
    check("srl_31", 64'(bus.ALUOut_next), 64'd1);
    instr(4'd7, 32'd0, 32'd0, 2'd0, 32'd0);
    step();
    check("nor_0", 64'(bus.ALUOut_next), 64'hFFFF_FFFF);
    instr(4'd12, 32'd3, 32'd3, 2'd0, 32'd0);
    step();
    check("op12_zero", 64'(bus.ALUOut_next), 64'd0);
    instr(4'd2, 32'd9, 32'd5, 2'd3, 32'd0);
    step();
    check("src3_zero", 64'(bus.ALUOut_next), 64'd9);
    check("src3_store", 64'(bus.stData_next), 64'd5);

    instr(4'd2, 32'd9, 32'd5, 2'd0, 32'd0);
    bus.in_valid = 1'b0; bus.dREN = 1'b1; bus.dWEN = 1'b1;
    step();
    check("bubble_valid", 64'(bus.valid_next), 64'd0);
    check("bubble_dren",  64'(bus.dREN_next), 64'd0);
    check("bubble_wen",   64'(bus.dWEN_next), 64'd0);
    check("bubble_alu",   64'(bus.ALUOut_next), 64'd14);
    instr(4'd2, 32'd1, 32'd1, 2'd0, 32'd0);
    bus.ihit = 1'b0;
    step();
    check("hold_alu",   64'(bus.ALUOut_next), 64'd14);
    check("hold_valid", 64'(bus.valid_next), 64'd0);
    bus.ihit = 1'b1;
    step();
    check("release_alu", 64'(bus.ALUOut_next), 64'd2);

    // Multiply: stall length and capture edge
    instr(4'd10, 32'h0000_FFFF, 32'h0001_0001, 2'd0, 32'd0);
    #1;
    busy_cnt = 0;
    while (bus.busy && busy_cnt < 40) begin
      busy_cnt++;
      step();
    end
    check("mul_busy_cycles", 64'(busy_cnt), MUL_EN ? 64'd33 : 64'd0);
    step();
    check("mul_result", 64'(bus.ALUOut_next), MUL_EN ? 64'hFFFF_FFFF : 64'd0);
    check("mul_valid",  64'(bus.valid_next), 64'd1);
    instr(4'd2, 32'd6, 32'd7, 2'd0, 32'd0);
    step();
    check("post_mul_add", 64'(bus.ALUOut_next), 64'd13);

    // Multiply waiting in DONE while ihit is low
    instr(4'd10, 32'd3, 32'd4, 2'd0, 32'd0);
    #1;
    busy_cnt = 0;
    while (bus.busy && busy_cnt < 40) begin
      busy_cnt++;
      step();
    end
    bus.ihit = 1'b0;
    step(); step(); step();
    check("done_hold", 64'(bus.ALUOut_next), 64'd13);
    bus.ihit = 1'b1;
    step();
    check("done_release", 64'(bus.ALUOut_next), MUL_EN ? 64'd12 : 64'd0);

    // Flush in the middle of a multiply
    instr(4'd10, 32'h1234, 32'h10, 2'd0, 32'd0);
    repeat (10) step();
    bus.flush = 1'b1;
    step();
    instr(4'd2, 32'd2, 32'd3, 2'd0, 32'd0);
    #1;
    check("flush_busy",  64'(bus.busy), 64'd0);
    check("flush_valid", 64'(bus.valid_next), 64'd0);
    check("flush_alu",   64'(bus.ALUOut_next), 64'd0);
    check("flush_regwr", 64'(bus.regWr_next), 64'd0);
    step();
    check("after_flush_add", 64'(bus.ALUOut_next), 64'd5);
    bus.flush = 1'b1;
    step();
    check("flush_beats_capture", 64'(bus.valid_next), 64'd0);

    // Reset in the middle of a multiply
    instr(4'd10, 32'd7, 32'd9, 2'd0, 32'd0);
    repeat (5) step();
    rst = 1'b1;
    #1;
    check("rst_busy",  64'(bus.busy), 64'd0);
    check("rst_valid", 64'(bus.valid_next), 64'd0);
    check("rst_alu",   64'(bus.ALUOut_next), 64'd0);
    step();
    rst = 1'b0;
    instr(4'd2, 32'd5, 32'd7, 2'd0, 32'd0);
    step();
    check("post_rst_add",   64'(bus.ALUOut_next), 64'd12);
    check("post_rst_valid", 64'(bus.valid_next), 64'd1);

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000 expected end earlier");
    $fatal(1);
  end
endmodule
